// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary-to-Gray stage between
// N_REQ valid/ready requesters; each result carries the winning requester index.
module gray_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_bin,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_gray,
    output logic [WIDTH-1:0]       out_bin,
    output logic [IDW-1:0]         out_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             acc;
    logic             take;
    logic             grant_hit;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign words[g] = req_bin[g*WIDTH +: WIDTH];
    end

    // Search from ptr upward with an explicit wrap so non-power-of-two N_REQ works.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_hit && req_valid[idx[IDW-1:0]]) begin
                grant_hit = 1'b1;
                grant_id  = idx[IDW-1:0];
            end
        end
    end

    assign acc      = ~out_valid | out_ready;
    assign take     = acc & grant_hit & ~rst;
    assign sel_word = words[grant_id];
    assign ptr_nxt  = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (take) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (!take && out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        req_ready = '0;
        if (take) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_gray <= '0;
            out_bin  <= '0;
            out_id   <= '0;
            ptr      <= '0;
        end else if (take) begin
            out_gray <= sel_word ^ (sel_word >> 1);
            out_bin  <= sel_word;
            out_id   <= grant_id;
            ptr      <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: vector table, directed multi-cycle
// sequences, and a round-robin reference model feeding an expected-result queue.
module tb_gray_conv_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_bin = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_gray;
    logic [W-1:0]  out_bin;
    logic [1:0]    out_id;

    int n_pass = 0;
    int n_total = 0;

    gray_conv_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected results queued at handshake, popped at consumption.
    typedef struct {
        logic [3:0] g;
        logic [3:0] b;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    bit   m_valid = 1'b0;
    int   m_ptr = 0;

    always @(negedge clk) begin
        exp_t       e;
        bit         acc;
        bit         hit;
        logic [1:0] idx;
        logic [1:0] gi;
        logic [3:0] exp_rdy;
        logic [3:0] w;
        if (rst) begin
            check("ready_in_reset", 32'(req_ready), 32'd0);
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else begin
            check("sb_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_gray", 32'(out_gray), 32'(e.g));
                    check("sb_bin", 32'(out_bin), 32'(e.b));
                    check("sb_id", 32'(out_id), 32'(e.id));
                end
            end
            acc     = !m_valid || out_ready;
            hit     = 1'b0;
            gi      = '0;
            exp_rdy = '0;
            if (acc) begin
                for (int k = 0; k < N; k++) begin
                    idx = 2'((m_ptr + k) % N);
                    if (!hit && ((req_valid >> idx) & 4'b1) != 4'b0) begin
                        hit = 1'b1;
                        gi  = idx;
                    end
                end
            end
            if (hit) exp_rdy = 4'b1 << gi;
            check("sb_req_ready", 32'(req_ready), 32'(exp_rdy));
            if (hit) begin
                w    = 4'(req_bin >> (4 * int'(gi)));
                e.g  = to_gray(w);
                e.b  = w;
                e.id = gi;
                sb.push_back(e);
                m_ptr   = (int'(gi) == N - 1) ? 0 : int'(gi) + 1;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    typedef struct {
        int         id;
        logic [3:0] word;
        logic [3:0] gray;
    } vec_t;

    vec_t       vt[7];
    logic [3:0] gtab[4];
    logic [3:0] prev_g;
    int         idx;

    initial begin
        vt[0] = '{2, 4'b0110, 4'b0101};
        vt[1] = '{0, 4'h0, 4'h0};
        vt[2] = '{3, 4'hF, 4'h8};
        vt[3] = '{1, 4'h8, 4'hC};
        vt[4] = '{2, 4'h7, 4'h4};
        vt[5] = '{0, 4'h1, 4'h1};
        vt[6] = '{1, 4'hA, 4'hF};
        gtab  = '{4'h1, 4'h4, 4'hC, 4'h8};

        // Reset state, with requests present that must not be granted
        req_valid = 4'b1111;
        cyc();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_gray", 32'(out_gray), 32'd0);
        check("rst_bin", 32'(out_bin), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        req_valid = '0;
        cyc();
        rst = 1'b0;

        // Table: single requester transactions
        for (int i = 0; i < 7; i++) begin
            cyc();
            req_valid = 4'(4'b1 << vt[i].id);
            req_bin   = 16'(vt[i].word) << (4 * vt[i].id);
            out_ready = 1'b1;
            #1;
            check("tbl_ready", 32'(req_ready), 32'(4'b1 << vt[i].id));
            cyc();
            req_valid = '0;
            check("tbl_valid", 32'(out_valid), 32'd1);
            check("tbl_gray", 32'(out_gray), 32'(vt[i].gray));
            check("tbl_bin", 32'(out_bin), 32'(vt[i].word));
            check("tbl_id", 32'(out_id), 32'(vt[i].id));
        end

        // All four valid from reset
        cyc();
        rst = 1'b1;
        cyc();
        check("rst2_valid", 32'(out_valid), 32'd0);
        rst       = 1'b0;
        req_bin   = {4'hF, 4'h8, 4'h7, 4'h1};
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("all_ready", 32'(req_ready), 32'(4'b1 << c));
            cyc();
            req_valid = req_valid & ~(4'b1 << c);
            check("all_id", 32'(out_id), 32'(c));
            check("all_gray", 32'(out_gray), 32'(gtab[c]));
        end
        // ptr back at 0; requester 1 drops out unserved and is skipped
        req_bin   = {4'h0, 4'h0, 4'h9, 4'h2};
        req_valid = 4'b0011;
        #1;
        check("ptr0_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        check("ptr0_id", 32'(out_id), 32'd0);

        // Backpressure for 5 cycles with all requesters waiting
        out_ready = 1'b0;
        req_bin   = {4'hD, 4'hC, 4'hB, 4'hA};
        req_valid = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_gray", 32'(out_gray), 32'h3);
            check("bp_bin", 32'(out_bin), 32'h2);
            check("bp_id", 32'(out_id), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idx = (1 + c) % N;
            #1;
            check("bp_order", 32'(req_ready), 32'(4'b1 << idx));
            cyc();
            req_valid = req_valid & ~(4'b1 << idx);
        end

        // Pointer wrap: grant 3, then 0 and 3 contend
        req_bin   = {4'h5, 4'h0, 4'h0, 4'h0};
        req_valid = 4'b1000;
        #1;
        check("wrap_first", 32'(req_ready), 32'b1000);
        cyc();
        req_bin   = {4'h6, 4'h0, 4'h0, 4'h3};
        req_valid = 4'b1001;
        #1;
        check("wrap_req0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b1000;
        #1;
        check("wrap_req3", 32'(req_ready), 32'b1000);
        cyc();
        req_valid = '0;
        out_ready = 1'b0;
        check("wrap_id", 32'(out_id), 32'd3);
        check("wrap_gray", 32'(out_gray), 32'h5);

        // Reset while holding a stalled result
        cyc();
        check("mid_held", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_valid", 32'(out_valid), 32'd0);
        check("mid_async_gray", 32'(out_gray), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        check("mid_after_rel", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        req_bin   = '0;
        req_valid = 4'b1111;
        #1;
        check("mid_ptr0", 32'(req_ready), 32'b0001);
        #1;
        req_valid = '0;
        cyc();
        check("mid_no_stale1", 32'(out_valid), 32'd0);
        cyc();
        check("mid_no_stale2", 32'(out_valid), 32'd0);

        // Back-to-back sweep from requester 1
        prev_g = '0;
        for (int n = 0; n < 16; n++) begin
            req_valid = 4'b0010;
            req_bin   = 16'(n) << 4;
            cyc();
            check("sw_bin", 32'(out_bin), 32'(n));
            check("sw_gray", 32'(out_gray), 32'(to_gray(4'(n))));
            if (n > 0) begin
                check("sw_onebit", 32'($countones(out_gray ^ prev_g)), 32'd1);
            end
            prev_g = out_gray;
        end
        req_valid = '0;
        cyc();
        cyc();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one binary-to-Gray conversion stage between N_REQ requesters using round-robin arbitration and valid/ready handshakes.
- Each grant converts one WIDTH-bit binary word to Gray code (G = B ^ (B >> 1)).
- The result is registered and tagged with the requester index.
- Sits between multiple pointer/counter producers and a single downstream consumer, e.g. a CDC pointer synchroniser or a status bus.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 4, binary/Gray word width; legal range 2..16.
- IDW, $clog2(N_REQ), width of the requester tag (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  N_REQ  bit i: requester i presents a word.
- req_bin  input  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  one-hot (or zero) grant; bit i high means word i is accepted this cycle.
- out_valid  output  1  registered result valid.
- out_ready  input  1  consumer accepts the result.
- out_gray  output  WIDTH  Gray-coded result.
- out_bin  output  WIDTH  original binary word (for checking).
- out_id  output  IDW  index of the requester that produced the result.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_gray=0, out_bin=0, out_id=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
  - Any held result is discarded and is not replayed after reset.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - The state is encoded by out_valid alone.
- Accept enable: acc = ~out_valid | out_ready. This is combinational and allows pass-through in the same cycle.
- Arbitration: combinational, evaluated only when acc=1.
  - Search req_valid starting at index ptr, ascending, wrapping from N_REQ-1 to 0.
  - The first set bit i wins, and req_ready[i]=1.
  - All other req_ready bits are 0.
  - req_ready must not depend on req_bin.
  - If acc=0 or no req_valid is set, req_ready=0.
- On a grant to i at clock edge:
  - out_valid<=1, out_bin<=word_i, out_gray<=word_i ^ (word_i >> 1), out_id<=i.
  - ptr<=(i+1) mod N_REQ.
  - For non-power-of-two N_REQ, the wrap is explicit, not a bit overflow.
- On out_valid & out_ready with no grant: out_valid<=0. Data registers hold their last values.
- No grant means ptr is unchanged.
- Latency: 1 cycle from the accepted req to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_* are held stable.
  - All req_ready are 0.
- Requester rules:
  - Once req_valid[i] is asserted, requester i holds req_valid[i] and its word stable until req_ready[i].
  - The block does not check this rule.
- Fairness: with all requesters continuously valid and out_ready=1, grant order is 0,1,...,N_REQ-1,0,...
  - No requester waits more than N_REQ grants.
- Boundaries:
  - Word all-ones gives Gray 1000..0.
  - Word zero gives Gray zero.
  - A requester dropping req_valid while not granted is simply skipped.
- Bus ordering: out_gray[WIDTH-1] = out_bin[WIDTH-1] (MSB passthrough). Bit k = out_bin[k] ^ out_bin[k+1].

Test Plan:
- Only requester 2 valid with word 4'b0110, out_ready=1:
  - req_ready=4'b0100 in that cycle.
  - The next cycle shows out_valid=1, out_gray=4'b0101, out_bin=4'b0110, out_id=2.
- All four valid simultaneously with words 4'h1, 4'h7, 4'h8, 4'hF, out_ready=1, from reset:
  - Results appear on consecutive cycles with ids 0,1,2,3.
  - Gray values are 4'h1, 4'h4, 4'hC, 4'h8.
  - ptr returns to 0.
- Backpressure: hold out_ready=0 for 5 cycles after the first result:
  - out_* are stable for those cycles.
  - req_ready=0 throughout.
  - After out_ready rises, the next grant goes to requester ptr, with no loss or duplication.
- Pointer wrap: grant requester 3, then requesters 0 and 3 valid together:
  - Requester 0 wins first, then requester 3.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0:
  - out_valid drops immediately without waiting for a clock.
  - ptr=0.
  - After release, the stale result never reappears.
- Exhaustive sweep: requester 1 sends words 0..15 back-to-back with out_ready=1:
  - Each out_gray matches out_bin ^ (out_bin >> 1).
  - Consecutive out_gray values differ in exactly one bit.
